// File: rtl/write_hazard_scoreboard_pkg.sv
// Shared types, sizing and helpers for the multi-record write hazard scoreboard.
// Table records, instruction-age comparison and the register chunk window live here.
package write_hazard_scoreboard_pkg;

  localparam int NR_RECORDS = 4;
  localparam int NR_CHECK   = 2;
  localparam int INST_IDX_W = 3;
  localparam int OFFSET_W   = 2;
  localparam int CHUNK_W    = 8 << OFFSET_W;
  localparam int OCC_W      = $clog2(NR_RECORDS + 1);
  localparam int SLOT_W     = (NR_RECORDS > 1) ? $clog2(NR_RECORDS) : 1;

  typedef logic [INST_IDX_W-1:0] inst_idx_t;
  typedef logic [CHUNK_W-1:0]    chunk_mask_t;

  typedef struct packed {
    logic        vdValid;
    logic        vs1Valid;
    logic        gather;
    logic        gather16;
    logic        onlyRead;
    logic [4:0]  vd;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    inst_idx_t   instIndex;
    chunk_mask_t elementMask;
  } record_t;

  // The MSB of an index is an epoch bit, so age ordering flips when epochs differ.
  function automatic logic older(input inst_idx_t req, input inst_idx_t rec);
    logic lowLess;
    lowLess = req[INST_IDX_W-2:0] < rec[INST_IDX_W-2:0];
    return (req == rec) | (lowLess ^ req[INST_IDX_W-1] ^ rec[INST_IDX_W-1]);
  endfunction

  // Completion map of a register group placed at its start register within two
  // consecutive 8-register groups; hi selects the upper group. 0 = chunk pending.
  function automatic chunk_mask_t regWindow(input logic [4:0] s, input chunk_mask_t mask,
                                            input logic hi);
    logic [3*CHUNK_W-1:0] framed;
    framed = {{CHUNK_W{1'b1}}, mask, {CHUNK_W{1'b1}}} << {s[2:0], {OFFSET_W{1'b0}}};
    return CHUNK_W'(framed >> (hi ? 2 * CHUNK_W : CHUNK_W));
  endfunction

endpackage

// File: rtl/write_hazard_scoreboard_if.sv
// Request/response bundle between the lane write path and the hazard scoreboard.
interface write_hazard_scoreboard_if;
  import write_hazard_scoreboard_pkg::*;

  // Allocate is a valid/ready handshake: it transfers on a cycle where alloc_valid
  // and alloc_ready are both high, and the master holds its payload stable until then.
  // Update, retire and check are fire-and-forget strobes; verdicts return a cycle later.
  logic        alloc_valid;
  logic        alloc_ready;
  logic        alloc_vd_valid;
  logic        alloc_vs1_valid;
  logic        alloc_gather;
  logic        alloc_gather16;
  logic        alloc_onlyRead;
  logic [4:0]  alloc_vd;
  logic [4:0]  alloc_vs1;
  logic [4:0]  alloc_vs2;
  inst_idx_t   alloc_instIndex;

  logic        upd_valid;
  inst_idx_t   upd_instIndex;
  chunk_mask_t upd_mask;

  logic        retire_valid;
  inst_idx_t   retire_instIndex;

  logic [NR_CHECK-1:0]                 chk_valid;
  logic [NR_CHECK-1:0][4:0]            chk_vd;
  logic [NR_CHECK-1:0][OFFSET_W-1:0]   chk_offset;
  logic [NR_CHECK-1:0][INST_IDX_W-1:0] chk_instIndex;

  logic [NR_CHECK-1:0] res_valid;
  logic [NR_CHECK-1:0] res_pass;
  logic [OCC_W-1:0]    occupancy;
  logic                err_dup_alloc;

  modport master (
    output alloc_valid, alloc_vd_valid, alloc_vs1_valid, alloc_gather, alloc_gather16,
           alloc_onlyRead, alloc_vd, alloc_vs1, alloc_vs2, alloc_instIndex,
           upd_valid, upd_instIndex, upd_mask, retire_valid, retire_instIndex,
           chk_valid, chk_vd, chk_offset, chk_instIndex,
    input  alloc_ready, res_valid, res_pass, occupancy, err_dup_alloc
  );

  modport slave (
    input  alloc_valid, alloc_vd_valid, alloc_vs1_valid, alloc_gather, alloc_gather16,
           alloc_onlyRead, alloc_vd, alloc_vs1, alloc_vs2, alloc_instIndex,
           upd_valid, upd_instIndex, upd_mask, retire_valid, retire_instIndex,
           chk_valid, chk_vd, chk_offset, chk_instIndex,
    output alloc_ready, res_valid, res_pass, occupancy, err_dup_alloc
  );

endinterface

// File: rtl/write_hazard_scoreboard_hazard_record_check.sv
// Combinational WAW/WAR evaluation of one write request against one table record.
module hazard_record_check
  import write_hazard_scoreboard_pkg::*;
(
  input  logic                recValid,
  input  record_t             rec,
  input  logic [4:0]          chkVd,
  input  logic [OFFSET_W-1:0] chkOffset,
  input  inst_idx_t           chkInstIndex,
  output logic                stall
);

  localparam int C_W = 3 + OFFSET_W;

  logic [C_W-1:0] chunk;
  logic [1:0]     grp;
  logic [1:0]     vdNext;
  logic [1:0]     vs2Next;
  chunk_mask_t    vdLo, vdHi, vs1Lo, vs2Lo, vs2Hi;
  logic           sameInst, reqOlder;
  logic           waw, war1, war2Lo, war2Hi;

  always_comb begin
    chunk   = {chkVd[2:0], chkOffset};
    grp     = chkVd[4:3];
    vdNext  = rec.vd[4:3] + 2'd1;
    vs2Next = rec.vs2[4:3] + 2'd1;

    vdLo  = regWindow(rec.vd,  rec.elementMask, 1'b0);
    vdHi  = regWindow(rec.vd,  rec.elementMask, 1'b1);
    vs1Lo = regWindow(rec.vs1, rec.elementMask, 1'b0);
    vs2Lo = regWindow(rec.vs2, rec.elementMask, 1'b0);
    vs2Hi = regWindow(rec.vs2, rec.elementMask, 1'b1);

    sameInst = chkInstIndex == rec.instIndex;
    reqOlder = older(chkInstIndex, rec.instIndex);

    waw = rec.vdValid & (((grp == rec.vd[4:3]) & ~vdLo[chunk]) |
                         ((grp == vdNext)      & ~vdHi[chunk]));
    war1 = rec.vs1Valid & (grp == rec.vs1[4:3]) & (~vs1Lo[chunk] | rec.gather16);
    // A read-only record has already consumed its low group, but not the spill-over.
    war2Lo = (grp == rec.vs2[4:3]) & ((~rec.onlyRead & ~vs2Lo[chunk]) | rec.gather);
    war2Hi = (grp == vs2Next) & (~vs2Hi[chunk] | rec.gather);

    stall = recValid & ~reqOlder & ~sameInst & (waw | war1 | war2Lo | war2Hi);
  end

endmodule

// File: rtl/write_hazard_scoreboard.sv
// Table of in-flight instruction records with allocate/update/retire handling and
// NR_CHECK pipelined write-hazard check ports returning registered verdicts.
module write_hazard_scoreboard
  import write_hazard_scoreboard_pkg::*;
(
  input logic                      clock,
  input logic                      reset,
  write_hazard_scoreboard_if.slave bus
);

  record_t                              recTable [NR_RECORDS];
  logic [NR_RECORDS-1:0]                slotValid;
  logic [NR_CHECK-1:0]                  resValid;
  logic [NR_CHECK-1:0]                  resPass;
  logic                                 errDup;

  logic                                 allocReady;
  logic                                 dupHit;
  logic                                 allocFire;
  logic [SLOT_W-1:0]                    allocSlot;
  logic [NR_RECORDS-1:0]                updHit;
  logic [NR_RECORDS-1:0]                retHit;
  logic [OCC_W-1:0]                     occCount;
  record_t                              allocRec;
  logic [NR_CHECK-1:0][NR_RECORDS-1:0]  stallVec;

  // Ready and all index matches look only at registered table state.
  always_comb begin
    allocReady = ~&slotValid;
    allocSlot  = '0;
    dupHit     = 1'b0;
    updHit     = '0;
    retHit     = '0;
    occCount   = '0;
    for (int r = NR_RECORDS - 1; r >= 0; r--) begin
      if (!slotValid[r]) allocSlot = SLOT_W'(r);
      if (slotValid[r] && recTable[r].instIndex == bus.alloc_instIndex) dupHit = 1'b1;
      retHit[r] = bus.retire_valid & slotValid[r] &
                  (recTable[r].instIndex == bus.retire_instIndex);
      updHit[r] = bus.upd_valid & slotValid[r] &
                  (recTable[r].instIndex == bus.upd_instIndex);
      occCount  = occCount + OCC_W'(slotValid[r]);
    end
    allocFire = bus.alloc_valid & allocReady & ~dupHit;

    allocRec             = '0;
    allocRec.vdValid     = bus.alloc_vd_valid;
    allocRec.vs1Valid    = bus.alloc_vs1_valid;
    allocRec.gather      = bus.alloc_gather;
    allocRec.gather16    = bus.alloc_gather16;
    allocRec.onlyRead    = bus.alloc_onlyRead;
    allocRec.vd          = bus.alloc_vd;
    allocRec.vs1         = bus.alloc_vs1;
    allocRec.vs2         = bus.alloc_vs2;
    allocRec.instIndex   = bus.alloc_instIndex;
  end

  // The allocated slot is free, so it never collides with an update or retire hit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slotValid <= '0;
      for (int r = 0; r < NR_RECORDS; r++) recTable[r] <= '0;
    end else begin
      for (int r = 0; r < NR_RECORDS; r++) begin
        if (retHit[r]) begin
          slotValid[r]             <= 1'b0;
          recTable[r].elementMask  <= '0;
        end else if (allocFire && allocSlot == SLOT_W'(r)) begin
          slotValid[r] <= 1'b1;
          recTable[r]  <= allocRec;
        end else if (updHit[r]) begin
          recTable[r].elementMask <= recTable[r].elementMask | bus.upd_mask;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) errDup <= 1'b0;
    else        errDup <= errDup | (bus.alloc_valid & allocReady & dupHit);
  end

  for (genvar i = 0; i < NR_CHECK; i++) begin : gChk
    for (genvar r = 0; r < NR_RECORDS; r++) begin : gRec
      hazard_record_check uCheck (
        .recValid     (slotValid[r]),
        .rec          (recTable[r]),
        .chkVd        (bus.chk_vd[i]),
        .chkOffset    (bus.chk_offset[i]),
        .chkInstIndex (bus.chk_instIndex[i]),
        .stall        (stallVec[i][r])
      );
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resValid <= '0;
      resPass  <= '0;
    end else begin
      for (int i = 0; i < NR_CHECK; i++) begin
        resValid[i] <= bus.chk_valid[i];
        resPass[i]  <= bus.chk_valid[i] & ~|stallVec[i];
      end
    end
  end

  assign bus.alloc_ready   = allocReady;
  assign bus.res_valid     = resValid;
  assign bus.res_pass      = resPass;
  assign bus.occupancy     = occCount;
  assign bus.err_dup_alloc = errDup;

endmodule

// File: tb/tb_write_hazard_scoreboard.sv
// Directed plus randomized bench for write_hazard_scoreboard against a chunk-level
// reference model of the in-flight record set.
module tb_write_hazard_scoreboard;
  import write_hazard_scoreboard_pkg::*;

  localparam int CHUNKS_PER_REG = 1 << OFFSET_W;
  localparam int HALF_IDX       = 1 << (INST_IDX_W - 1);
  localparam int EXP_W          = 2 * NR_CHECK;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  write_hazard_scoreboard_if bus();

  write_hazard_scoreboard dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int          idx;
    bit          vdValid, vs1Valid, gather, gather16, onlyRead;
    int          vd, vs1, vs2;
    bit [CHUNK_W-1:0] mask;
  } mrec_t;

  mrec_t recs[$];
  bit    mErr;
  logic [EXP_W-1:0] exp_q[$];
  int    nAsserts = 0;
  int    nFails   = 0;

  // Chunk c of group g, seen as an element chunk of a register group starting at s.
  function automatic bit mPending(int s, bit [CHUNK_W-1:0] mask, int g, int c);
    int d, k;
    d = (g - s / 8 + 4) % 4;
    k = d * CHUNK_W + c - (s % 8) * CHUNKS_PER_REG;
    if (d > 1 || k < 0 || k >= CHUNK_W) return 1'b0;
    return !mask[k];
  endfunction

  function automatic bit mOlder(int req, int rec);
    bit lowLess, epochDiff;
    lowLess   = (req % HALF_IDX) < (rec % HALF_IDX);
    epochDiff = (req / HALF_IDX) != (rec / HALF_IDX);
    return (req == rec) || (lowLess ^ epochDiff);
  endfunction

  function automatic bit mStall(mrec_t r, int vd, int off, int idx);
    int g, c, d1, d2;
    bit waw, war1, war2;
    g    = vd / 8;
    c    = (vd % 8) * CHUNKS_PER_REG + off;
    d1   = (g - r.vs1 / 8 + 4) % 4;
    d2   = (g - r.vs2 / 8 + 4) % 4;
    waw  = r.vdValid && mPending(r.vd, r.mask, g, c);
    war1 = r.vs1Valid && d1 == 0 && (mPending(r.vs1, r.mask, g, c) || r.gather16);
    war2 = (d2 == 0 && ((!r.onlyRead && mPending(r.vs2, r.mask, g, c)) || r.gather)) ||
           (d2 == 1 && (mPending(r.vs2, r.mask, g, c) || r.gather));
    return !mOlder(idx, r.idx) && (waw || war1 || war2);
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic expectEq(string tag, logic [63:0] obs, logic [63:0] expv);
    nAsserts++;
    assert (obs === expv) else begin
      nFails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drvIdle();
    bus.alloc_valid = 0; bus.alloc_vd_valid = 0; bus.alloc_vs1_valid = 0;
    bus.alloc_gather = 0; bus.alloc_gather16 = 0; bus.alloc_onlyRead = 0;
    bus.alloc_vd = '0; bus.alloc_vs1 = '0; bus.alloc_vs2 = '0; bus.alloc_instIndex = '0;
    bus.upd_valid = 0; bus.upd_instIndex = '0; bus.upd_mask = '0;
    bus.retire_valid = 0; bus.retire_instIndex = '0;
    bus.chk_valid = '0; bus.chk_vd = '0; bus.chk_offset = '0; bus.chk_instIndex = '0;
  endtask

  task automatic drvAlloc(int idx, bit vdv, int vd, bit vs1v, int vs1, int vs2,
                          bit ga, bit g16, bit ro);
    bus.alloc_valid = 1; bus.alloc_instIndex = INST_IDX_W'(idx);
    bus.alloc_vd_valid = vdv; bus.alloc_vd = 5'(vd);
    bus.alloc_vs1_valid = vs1v; bus.alloc_vs1 = 5'(vs1); bus.alloc_vs2 = 5'(vs2);
    bus.alloc_gather = ga; bus.alloc_gather16 = g16; bus.alloc_onlyRead = ro;
  endtask

  task automatic drvUpd(int idx, bit [CHUNK_W-1:0] mask);
    bus.upd_valid = 1; bus.upd_instIndex = INST_IDX_W'(idx); bus.upd_mask = mask;
  endtask

  task automatic drvRetire(int idx);
    bus.retire_valid = 1; bus.retire_instIndex = INST_IDX_W'(idx);
  endtask

  task automatic drvCheck(int port, int vd, int off, int idx);
    bus.chk_valid[port] = 1; bus.chk_vd[port] = 5'(vd);
    bus.chk_offset[port] = OFFSET_W'(off); bus.chk_instIndex[port] = INST_IDX_W'(idx);
  endtask

  // Model this cycle's inputs, clock once, then compare all outputs.
  task automatic step();
    logic [EXP_W-1:0] e;
    mrec_t pre[$];
    mrec_t nr;
    bit p, dup;
    e   = '0;
    pre = recs;
    for (int i = 0; i < NR_CHECK; i++) begin
      if (bus.chk_valid[i]) begin
        p = 1'b1;
        foreach (pre[j])
          if (mStall(pre[j], int'(bus.chk_vd[i]), int'(bus.chk_offset[i]),
                     int'(bus.chk_instIndex[i]))) p = 1'b0;
        e[2*i+1] = 1'b1;
        e[2*i]   = p;
      end
    end
    exp_q.push_back(e);

    if (bus.upd_valid && !(bus.retire_valid && bus.retire_instIndex == bus.upd_instIndex))
      foreach (recs[j])
        if (recs[j].idx == int'(bus.upd_instIndex)) recs[j].mask |= bus.upd_mask;
    if (bus.retire_valid)
      for (int j = recs.size() - 1; j >= 0; j--)
        if (recs[j].idx == int'(bus.retire_instIndex)) recs.delete(j);
    if (bus.alloc_valid && pre.size() < NR_RECORDS) begin
      dup = 1'b0;
      foreach (pre[j]) if (pre[j].idx == int'(bus.alloc_instIndex)) dup = 1'b1;
      if (dup) mErr = 1'b1;
      else begin
        nr.idx = int'(bus.alloc_instIndex);
        nr.vdValid = bus.alloc_vd_valid; nr.vs1Valid = bus.alloc_vs1_valid;
        nr.gather = bus.alloc_gather; nr.gather16 = bus.alloc_gather16;
        nr.onlyRead = bus.alloc_onlyRead;
        nr.vd = int'(bus.alloc_vd); nr.vs1 = int'(bus.alloc_vs1); nr.vs2 = int'(bus.alloc_vs2);
        nr.mask = '0;
        recs.push_back(nr);
      end
    end

    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    for (int i = 0; i < NR_CHECK; i++) begin
      expectEq($sformatf("res_valid[%0d]", i), 64'(bus.res_valid[i]), 64'(e[2*i+1]));
      if (e[2*i+1])
        expectEq($sformatf("res_pass[%0d]", i), 64'(bus.res_pass[i]), 64'(e[2*i]));
    end
    expectEq("occupancy", 64'(bus.occupancy), 64'(recs.size()));
    expectEq("alloc_ready", 64'(bus.alloc_ready), 64'(recs.size() < NR_RECORDS));
    expectEq("err_dup_alloc", 64'(bus.err_dup_alloc), 64'(mErr));
    drvIdle();
  endtask

  task automatic checkResetOutputs(string tag);
    expectEq({tag, "_res_valid"}, 64'(bus.res_valid), 64'(0));
    expectEq({tag, "_res_pass"}, 64'(bus.res_pass), 64'(0));
    expectEq({tag, "_occupancy"}, 64'(bus.occupancy), 64'(0));
    expectEq({tag, "_err"}, 64'(bus.err_dup_alloc), 64'(0));
    expectEq({tag, "_alloc_ready"}, 64'(bus.alloc_ready), 64'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drvIdle();
    mErr  = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkResetOutputs("reset");
    reset = 1'b1;

    // Empty table passes everything.
    drvCheck(0, 3, 1, 2); step();

    // WAW on an incomplete destination, cleared by a progress update.
    drvAlloc(1, 1, 8, 0, 0, 0, 0, 0, 0); step();
    drvCheck(0, 9, 2, 2); step();
    drvUpd(1, 32'h0000_0040); step();
    drvCheck(0, 9, 2, 2); drvCheck(1, 9, 3, 2); step();
    drvRetire(1); step();

    // Gather source spilling into the next group.
    drvAlloc(5, 0, 0, 0, 0, 16, 1, 0, 0); step();
    drvCheck(0, 24, 0, 6); drvCheck(1, 16, 0, 6); step();
    drvRetire(5); step();
    drvAlloc(5, 0, 0, 0, 0, 17, 0, 0, 1); step();
    drvCheck(1, 24, 0, 6); drvCheck(0, 16, 2, 6); step();
    drvRetire(5); step();

    // Epoch wrap: index 0 is younger than 7.
    drvAlloc(7, 1, 0, 0, 0, 8, 0, 0, 0); step();
    drvCheck(0, 0, 0, 0); step();
    drvRetire(7); drvCheck(1, 0, 0, 0); step();
    drvCheck(0, 0, 0, 0); drvCheck(1, 0, 1, 0); step();

    // Fill the table, then retire and allocate together.
    for (int k = 0; k < NR_RECORDS; k++) begin
      drvAlloc(k, 1, k * 8, 1, k * 8 + 1, k * 8 + 2, 0, 0, 0); step();
    end
    drvRetire(0); drvAlloc(4, 1, 4, 0, 0, 12, 0, 0, 0); step();
    drvAlloc(4, 1, 4, 0, 0, 12, 0, 0, 0); step();

    // Duplicate allocate is dropped and flagged.
    drvRetire(1); step();
    drvAlloc(2, 1, 20, 0, 0, 0, 0, 0, 0); drvCheck(0, 20, 1, 5); step();

    // Asynchronous reset mid-stream.
    reset = 1'b0;
    #1;
    checkResetOutputs("midreset");
    recs.delete(); exp_q.delete(); mErr = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;

    // Randomized traffic against the model.
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 1) == 1)
        drvAlloc($urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 31),
                 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) == 0) drvUpd($urandom_range(0, 7), $urandom | $urandom);
      if ($urandom_range(0, 2) == 0) drvRetire($urandom_range(0, 7));
      for (int p = 0; p < NR_CHECK; p++)
        if ($urandom_range(0, 3) != 0)
          drvCheck(p, $urandom_range(0, 31), $urandom_range(0, CHUNKS_PER_REG - 1),
                   $urandom_range(0, 7));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
